// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// master drives the requests; slave (the controller) returns stall/flush/redirect.
interface pipeline_ctrl_if;
   logic        stallreq_from_id;
   logic        stallreq_from_ex;
   logic [5:0]  ex_cycles;
   logic [31:0] excepttype_i;
   logic [31:0] epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        busy;

   modport master (
      output stallreq_from_id,
      output stallreq_from_ex,
      output ex_cycles,
      output excepttype_i,
      output epc_i,
      input  stall,
      input  flush,
      input  new_pc,
      input  busy
   );

   modport slave (
      input  stallreq_from_id,
      input  stallreq_from_ex,
      input  ex_cycles,
      input  excepttype_i,
      input  epc_i,
      output stall,
      output flush,
      output new_pc,
      output busy
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with multi-cycle EX hold.
// Define CTRL_STALL_STATS_EN to add the saturating stall_cnt output.
module pipeline_ctrl (
   input  logic            clk,
   input  logic            rst,
`ifdef CTRL_STALL_STATS_EN
   output logic [15:0]     stall_cnt,
`endif
   pipeline_ctrl_if.slave  bus
);

   typedef enum logic {RUN, EX_WAIT} state_t;

   localparam logic [5:0]  STALL_NONE = 6'b000000;
   localparam logic [5:0]  STALL_EX   = 6'b001111;
   localparam logic [5:0]  STALL_ID   = 6'b000111;
   localparam logic [31:0] EXC_ERET   = 32'h0000000E;
   localparam logic [31:0] EXC_VEC    = 32'h00000020;

   state_t      r_state;
   state_t      w_state_nx;
   logic [5:0]  r_cnt;
   logic [5:0]  w_cnt_nx;
   logic [5:0]  w_n;
   logic [5:0]  w_stall;
   logic        w_flush;
   logic [31:0] w_new_pc;

   assign w_n = (bus.ex_cycles == 6'd0) ? 6'd1 : bus.ex_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
         r_cnt   <= 6'd0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_stall    = STALL_NONE;
      w_flush    = 1'b0;
      w_new_pc   = 32'h0;
      if (rst) begin
         w_state_nx = RUN;
         w_cnt_nx   = 6'd0;
      end else if (bus.excepttype_i != 32'h0) begin
         w_flush    = 1'b1;
         w_new_pc   = (bus.excepttype_i == EXC_ERET) ? bus.epc_i : EXC_VEC;
         w_state_nx = RUN;
         w_cnt_nx   = 6'd0;
      end else if (r_state == EX_WAIT) begin
         // requests are ignored here; hold until the counted cycles run out
         w_stall = STALL_EX;
         if (r_cnt <= 6'd1) begin
            w_state_nx = RUN;
            w_cnt_nx   = 6'd0;
         end else begin
            w_cnt_nx = r_cnt - 6'd1;
         end
      end else if (bus.stallreq_from_ex) begin
         w_stall = STALL_EX;
         if (w_n > 6'd1) begin
            w_state_nx = EX_WAIT;
            w_cnt_nx   = w_n - 6'd1;
         end
      end else if (bus.stallreq_from_id) begin
         w_stall = STALL_ID;
      end
   end

   assign bus.stall  = w_stall;
   assign bus.flush  = w_flush;
   assign bus.new_pc = w_new_pc;
   assign bus.busy   = !rst && (r_state != RUN);

`ifdef CTRL_STALL_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= 16'd0;
      else if ((w_stall != STALL_NONE) && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_pipeline_ctrl;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   pipeline_ctrl_if bus ();

`ifdef CTRL_STALL_STATS_EN
   logic [15:0] stall_cnt;
   pipeline_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .stall_cnt (stall_cnt),
      .bus       (bus.slave)
   );
`else
   pipeline_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic id, input logic ex,
                        input logic [5:0] cyc,
                        input logic [31:0] exc,
                        input logic [31:0] epc);
      bus.stallreq_from_id = id;
      bus.stallreq_from_ex = ex;
      bus.ex_cycles        = cyc;
      bus.excepttype_i     = exc;
      bus.epc_i            = epc;
   endtask

   task automatic step(input string tag,
                       input logic [5:0]  es,
                       input logic        ef,
                       input logic [31:0] ep,
                       input logic        eb);
      @(negedge clk);
      chk({tag, ".stall"},  {26'd0, bus.stall}, {26'd0, es});
      chk({tag, ".flush"},  {31'd0, bus.flush}, {31'd0, ef});
      chk({tag, ".new_pc"}, bus.new_pc, ep);
      chk({tag, ".busy"},   {31'd0, bus.busy},  {31'd0, eb});
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      rst = 1'b1;
      drive(1, 1, 6'd5, 32'hE, 32'h1234);
      step("rst0", 6'h00, 0, 32'h0, 0);
      step("rst1", 6'h00, 0, 32'h0, 0);

      rst = 1'b0;
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("idle", 6'h00, 0, 32'h0, 0);

      drive(0, 1, 6'd5, 32'h0, 32'h0);
      step("ex5_c1", 6'h0F, 0, 32'h0, 0);
      drive(1, 1, 6'd5, 32'h0, 32'h0);
      for (int i = 2; i <= 5; i++)
         step($sformatf("ex5_c%0d", i), 6'h0F, 0, 32'h0, 1);
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("ex5_end", 6'h00, 0, 32'h0, 0);

      drive(1, 0, 6'd0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++)
         step($sformatf("id_c%0d", i), 6'h07, 0, 32'h0, 0);

      drive(0, 1, 6'd0, 32'h0, 32'h0);
      step("ex0", 6'h0F, 0, 32'h0, 0);
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("ex0_end", 6'h00, 0, 32'h0, 0);

      drive(1, 1, 6'd2, 32'h0, 32'h0);
      step("both_c1", 6'h0F, 0, 32'h0, 0);
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("both_c2", 6'h0F, 0, 32'h0, 1);
      step("both_end", 6'h00, 0, 32'h0, 0);

      drive(0, 1, 6'd10, 32'h0, 32'h0);
      step("ex10_c1", 6'h0F, 0, 32'h0, 0);
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("ex10_c2", 6'h0F, 0, 32'h0, 1);
      drive(0, 0, 6'd0, 32'h1, 32'h0);
      step("exc_wait", 6'h00, 1, 32'h20, 1);
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("exc_after", 6'h00, 0, 32'h0, 0);

      drive(0, 1, 6'd3, 32'hE, 32'h1234);
      step("eret", 6'h00, 1, 32'h1234, 0);
      drive(0, 0, 6'd0, 32'h0, 32'h1234);
      step("noflush", 6'h00, 0, 32'h0, 0);

      drive(0, 1, 6'd6, 32'h0, 32'h0);
      step("ex6_c1", 6'h0F, 0, 32'h0, 0);
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("ex6_c2", 6'h0F, 0, 32'h0, 1);
      rst = 1'b1;
      drive(1, 1, 6'd6, 32'h4, 32'h5);
      step("rst_mid", 6'h00, 0, 32'h0, 0);
      rst = 1'b0;
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("post_rst", 6'h00, 0, 32'h0, 0);

      drive(0, 1, 6'd1, 32'h0, 32'h0);
      step("ex1", 6'h0F, 0, 32'h0, 0);
      drive(0, 0, 6'd0, 32'h0, 32'h0);
      step("ex1_end", 6'h00, 0, 32'h0, 0);

`ifdef CTRL_STALL_STATS_EN
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("scnt_clr", {16'd0, stall_cnt}, 32'h0);
      drive(0, 1, 6'd0, 32'h0, 32'h0);
      for (int i = 0; i < 70000; i++)
         @(posedge clk);
      #1;
      @(negedge clk);
      chk("scnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("scnt_hold", {16'd0, stall_cnt}, 32'hFFFF);
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("scnt_rst", {16'd0, stall_cnt}, 32'h0);
      rst = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: stallreq_from_id  input  1  decode-stage load-use stall request.
REQ-004 SHALL provide: stallreq_from_ex  input  1  execute-stage multi-cycle operation request (mult/div).
REQ-005 SHALL provide: ex_cycles  input  6  total stall cycles the EX operation needs; 0 treated as 1.
REQ-006 SHALL provide: excepttype_i  input  32  exception type from MEM; nonzero = flush request.
REQ-007 SHALL provide: epc_i  input  32  return address used for eret.
REQ-008 SHALL provide: stall  output  6  hold vector; bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb.
REQ-009 SHALL provide: flush  output  1  clear all pipeline registers this cycle.
REQ-010 SHALL provide: new_pc  output  32  redirect target, valid when flush=1.
REQ-011 SHALL provide: busy  output  1  high while state is not RUN.

Function
REQ-012 SHALL implement states RUN and EX_WAIT, plus a 6-bit down-counter cnt.
REQ-013 stall, flush and new_pc SHALL be combinational from current state, cnt and inputs (zero-latency to pipeline registers).
REQ-014 Priority SHALL be exception > EX request/EX_WAIT > ID request.
REQ-015 Exception (excepttype_i != 0) in any state: flush=1, stall=6'b000000, next state RUN, cnt cleared.
REQ-016 new_pc SHALL be epc_i when excepttype_i = 32'h0000000E (eret), else 32'h00000020; 32'h0 when flush=0.
REQ-017 RUN with stallreq_from_ex=1: stall=6'b001111; N = max(ex_cycles,1); if N>1 load cnt=N-1 and go EX_WAIT, else stay RUN.
REQ-018 EX_WAIT: stall=6'b001111; cnt decrements each cycle; when cnt==1 next state RUN; total held cycles SHALL equal N exactly.
REQ-019 stallreq_from_ex and stallreq_from_id SHALL be ignored while in EX_WAIT.
REQ-020 RUN with only stallreq_from_id=1: stall=6'b000111, state unchanged.
REQ-021 RUN with no requests: stall=6'b000000, flush=0.
REQ-022 Simultaneous ID and EX requests in RUN SHALL be treated as an EX request (REQ-017).

Reset
REQ-023 While rst=1 at a rising edge: state<=RUN, cnt<=0.
REQ-024 While rst=1: stall=0, flush=0, new_pc=0, busy=0 regardless of inputs.
REQ-025 Reset asserted mid-EX_WAIT SHALL abort the sequence; first cycle after release behaves as RUN.

Configuration
REQ-026 With CTRL_STALL_STATS_EN defined: output stall_cnt[15:0] SHALL count cycles with stall!=0, saturate at 16'hFFFF, clear on rst.
REQ-027 Without CTRL_STALL_STATS_EN: stall_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 rst=1 two cycles with all requests high -> stall=0, flush=0, new_pc=0, busy=0.
REQ-029 RUN, stallreq_from_ex=1 for 1 cycle with ex_cycles=5 -> stall=6'b001111 for exactly 5 cycles, busy=1 cycles 2-5, then stall=0.
REQ-030 stallreq_from_id=1 for 3 cycles -> stall=6'b000111 each cycle, busy=0; ex_cycles=0 with stallreq_from_ex -> single 6'b001111 cycle.
REQ-031 In EX_WAIT (ex_cycles=10, cycle 3) excepttype_i=32'h1 -> flush=1, new_pc=32'h00000020, stall=0 same cycle, RUN next cycle.
REQ-032 excepttype_i=32'h0000000E, epc_i=32'h00001234 -> flush=1, new_pc=32'h00001234.
REQ-033 With CTRL_STALL_STATS_EN: 70000 consecutive stall cycles -> stall_cnt=16'hFFFF held; rst -> 0.
